// File: rtl/synth_pkg.sv
// Shared types and helpers for the polyphonic voice allocator and mixer.
package synth_pkg;

   localparam int unsigned MIDI_NOTE_W = 7;
   localparam int unsigned RATE_MAX_W  = 32;
   localparam int unsigned AGE_MAX_W   = 16;

   // Fields are sized for the widest supported configuration; the top uses the low bits.
   typedef struct packed {
      logic                   on;
      logic [MIDI_NOTE_W-1:0] note;
      logic [RATE_MAX_W-1:0]  rate;
      logic [AGE_MAX_W-1:0]   age;
   } voice_state_t;

   typedef enum logic [1:0] {IDLE, LOOKUP, COMMIT} alloc_state_t;

   function automatic int unsigned ceil_log2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int k = 0; k < 31; k++) begin
         if ((32'd1 << k) < n) r = k + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/voice_mix_pipe.sv
// Two-stage mixer: sum of active voice samples, then normalising arithmetic shift.
module voice_mix_pipe
   import synth_pkg::*;
#(
   parameter int unsigned NUM_VOICES   = 8,
   parameter int unsigned SAMPLE_WIDTH = 16,
   parameter int unsigned NORM_MODE    = 1
) (
   input  logic                                   clk_in,
   input  logic                                   rst_in,
   input  logic                                   strobe_in,
   input  logic [NUM_VOICES-1:0]                  is_on_in,
   input  logic [NUM_VOICES-1:0][SAMPLE_WIDTH-1:0] samples_in,
   output logic [SAMPLE_WIDTH-1:0]                stream_out,
   output logic                                   valid_out
);

   localparam int unsigned IDX_W = $clog2(NUM_VOICES);
   localparam int unsigned SUM_W = SAMPLE_WIDTH + IDX_W;
   localparam int unsigned CNT_W = IDX_W + 1;

   logic signed [SUM_W-1:0]  sum_d, sum_q;
   logic [CNT_W-1:0]         count;
   logic [CNT_W-1:0]         shift_d, shift_q;
   logic                     v1_q, v2_q;
   logic [SAMPLE_WIDTH-1:0]  stream_q;

   always_comb begin
      sum_d = '0;
      count = '0;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
         if (is_on_in[i]) begin
            sum_d = sum_d + SUM_W'(signed'(samples_in[i]));
            count = count + CNT_W'(1);
         end
      end
      if (NORM_MODE == 0) shift_d = CNT_W'(IDX_W);
      else                shift_d = CNT_W'(ceil_log2(32'(count)));
   end

   // Stage 1 captures a new strobe while stage 2 finishes the previous one.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sum_q    <= '0;
         shift_q  <= '0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         stream_q <= '0;
      end else begin
         v1_q <= strobe_in;
         v2_q <= v1_q;
         if (strobe_in) begin
            sum_q   <= sum_d;
            shift_q <= shift_d;
         end
         if (v1_q) stream_q <= SAMPLE_WIDTH'(sum_q >>> shift_q);
      end
   end

   assign stream_out = stream_q;
   assign valid_out  = v2_q;

endmodule

// File: rtl/poly_voice_mixer.sv
// Note-event voice allocator (retrigger / free / steal-oldest) feeding a normalising mixer.
module poly_voice_mixer
   import synth_pkg::*;
#(
   parameter int unsigned NUM_VOICES   = 8,
   parameter int unsigned SAMPLE_WIDTH = 16,
   parameter int unsigned RATE_WIDTH   = 24,
   parameter int unsigned AGE_WIDTH    = 8,
   parameter int unsigned NORM_MODE    = 1
) (
   input  logic                                   clk_in,
   input  logic                                   rst_in,
   input  logic                                   evt_valid_in,
   output logic                                   evt_ready_out,
   input  logic                                   evt_note_on_in,
   input  logic [MIDI_NOTE_W-1:0]                 evt_note_in,
   input  logic [RATE_WIDTH-1:0]                  evt_rate_in,
   output logic [NUM_VOICES-1:0]                  is_on_out,
   output logic [NUM_VOICES-1:0][RATE_WIDTH-1:0]  rate_out,
   input  logic [NUM_VOICES-1:0][SAMPLE_WIDTH-1:0] samples_in,
   input  logic                                   sample_strobe_in,
   output logic [SAMPLE_WIDTH-1:0]                stream_out,
   output logic                                   stream_valid_out,
   output logic                                   steal_out
);

   localparam int unsigned IDX_W = $clog2(NUM_VOICES);
   localparam logic [AGE_MAX_W-1:0] AGE_SAT = AGE_MAX_W'((32'd1 << AGE_WIDTH) - 32'd1);

   alloc_state_t           state_q, state_d;
   logic                   accept;
   logic                   evt_on_q;
   logic [MIDI_NOTE_W-1:0] evt_note_q;
   logic [RATE_WIDTH-1:0]  evt_rate_q;
   voice_state_t           voice_q [NUM_VOICES];
   voice_state_t           voice_d [NUM_VOICES];
   logic                   match_found_d, match_found_q, free_found_d, free_found_q;
   logic [IDX_W-1:0]       match_idx_d, match_idx_q, free_idx_d, free_idx_q;
   logic [IDX_W-1:0]       oldest_idx_d, oldest_idx_q, tgt;
   logic [AGE_MAX_W-1:0]   oldest_age;
   logic                   steal_d, steal_q;

   assign evt_ready_out = (state_q == IDLE);
   assign accept        = evt_valid_in & evt_ready_out;
   assign steal_out     = steal_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = LOOKUP;
         LOOKUP:  state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Descending scan so the lowest matching/free index wins.
   always_comb begin
      match_found_d = 1'b0;
      match_idx_d   = '0;
      free_found_d  = 1'b0;
      free_idx_d    = '0;
      for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
         if (voice_q[i].on && voice_q[i].note == evt_note_q) begin
            match_found_d = 1'b1;
            match_idx_d   = IDX_W'(i);
         end
         if (!voice_q[i].on) begin
            free_found_d = 1'b1;
            free_idx_d   = IDX_W'(i);
         end
      end
      oldest_idx_d = '0;
      oldest_age   = voice_q[0].age;
      for (int i = 1; i < int'(NUM_VOICES); i++) begin
         if (voice_q[i].age > oldest_age) begin
            oldest_age   = voice_q[i].age;
            oldest_idx_d = IDX_W'(i);
         end
      end
   end

   always_comb begin
      voice_d = voice_q;
      steal_d = 1'b0;
      tgt     = '0;
      if (state_q == COMMIT) begin
         if (evt_on_q) begin
            if (match_found_q)     tgt = match_idx_q;
            else if (free_found_q) tgt = free_idx_q;
            else begin
               tgt     = oldest_idx_q;
               steal_d = 1'b1;
            end
            for (int i = 0; i < int'(NUM_VOICES); i++) begin
               if (IDX_W'(i) == tgt) begin
                  voice_d[i].on   = 1'b1;
                  voice_d[i].note = evt_note_q;
                  voice_d[i].rate = RATE_MAX_W'(evt_rate_q);
                  voice_d[i].age  = '0;
               end else if (voice_q[i].on && voice_q[i].age != AGE_SAT) begin
                  voice_d[i].age = voice_q[i].age + AGE_MAX_W'(1);
               end
            end
         end else if (match_found_q) begin
            voice_d[match_idx_q].on  = 1'b0;
            voice_d[match_idx_q].age = '0;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q       <= IDLE;
         evt_on_q      <= 1'b0;
         evt_note_q    <= '0;
         evt_rate_q    <= '0;
         match_found_q <= 1'b0;
         match_idx_q   <= '0;
         free_found_q  <= 1'b0;
         free_idx_q    <= '0;
         oldest_idx_q  <= '0;
         steal_q       <= 1'b0;
         for (int i = 0; i < int'(NUM_VOICES); i++) voice_q[i] <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            // A note-on with zero rate behaves as a note-off.
            evt_on_q   <= evt_note_on_in && (evt_rate_in != '0);
            evt_note_q <= evt_note_in;
            evt_rate_q <= evt_rate_in;
         end
         match_found_q <= match_found_d;
         match_idx_q   <= match_idx_d;
         free_found_q  <= free_found_d;
         free_idx_q    <= free_idx_d;
         oldest_idx_q  <= oldest_idx_d;
         steal_q       <= steal_d;
         voice_q       <= voice_d;
      end
   end

   always_comb begin
      is_on_out = '0;
      rate_out  = '0;
      for (int i = 0; i < int'(NUM_VOICES); i++) begin
         is_on_out[i] = voice_q[i].on;
         rate_out[i]  = voice_q[i].rate[RATE_WIDTH-1:0];
      end
   end

   voice_mix_pipe #(
      .NUM_VOICES   (NUM_VOICES),
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .NORM_MODE    (NORM_MODE)
   ) u_mix (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .strobe_in  (sample_strobe_in),
      .is_on_in   (is_on_out),
      .samples_in (samples_in),
      .stream_out (stream_out),
      .valid_out  (stream_valid_out)
   );

endmodule
